// File: rtl/axis_broadcaster_1to2_if.sv
`default_nettype none
// ============================================================================
// Module   : axis_broadcaster_1to2_if
// Brief    : AXI4-Stream channel (tdata/tvalid/tlast/tready) with modports.
// Revision : 1.0
// ============================================================================

interface axis_broadcaster_1to2_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

`default_nettype wire

// File: rtl/axis_broadcaster_1to2.sv
`default_nettype none
// ============================================================================
// Module   : axis_broadcaster_1to2
// Brief    : One-to-two AXI4-Stream broadcaster, single register stage with
//            independently released branches.
// Revision : 1.0
// ============================================================================

module axis_broadcaster_1to2 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    AXIS_ACLK,
  input  logic                    AXIS_ARESET,
  axis_broadcaster_1to2_if.slave  s_axis,
  axis_broadcaster_1to2_if.master m_axis1,
  axis_broadcaster_1to2_if.master m_axis2
);

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_last;
  logic                  r_v1;
  logic                  r_v2;

  logic w_free1;
  logic w_free2;
  logic w_s_ready;
  logic w_accept;
  logic w_hs1;
  logic w_hs2;

  // A branch is free when it holds nothing or is emptying this cycle; the
  // shared register may only be reloaded once both branches are free.
  assign w_free1   = !r_v1 || m_axis1.tready;
  assign w_free2   = !r_v2 || m_axis2.tready;
  assign w_s_ready = !AXIS_ARESET && w_free1 && w_free2;
  assign w_accept  = s_axis.tvalid && w_s_ready;
  assign w_hs1     = r_v1 && m_axis1.tready;
  assign w_hs2     = r_v2 && m_axis2.tready;

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      r_data <= '0;
      r_last <= 1'b0;
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
    end else if (w_accept) begin
      // A new beat re-arms both branches, overriding any same-cycle clear.
      r_data <= s_axis.tdata;
      r_last <= s_axis.tlast;
      r_v1   <= 1'b1;
      r_v2   <= 1'b1;
    end else begin
      if (w_hs1) begin
        r_v1 <= 1'b0;
      end
      if (w_hs2) begin
        r_v2 <= 1'b0;
      end
    end
  end

  assign s_axis.tready  = w_s_ready;

  assign m_axis1.tdata  = r_data;
  assign m_axis1.tlast  = r_last;
  assign m_axis1.tvalid = r_v1;

  assign m_axis2.tdata  = r_data;
  assign m_axis2.tlast  = r_last;
  assign m_axis2.tvalid = r_v2;

endmodule

`default_nettype wire

// File: tb/tb_axis_broadcaster_1to2.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_broadcaster_1to2
// Brief    : Directed and randomised self-checking bench for the broadcaster.
// Revision : 1.0
// ============================================================================

module tb_axis_broadcaster_1to2;

  localparam int DW     = 32;
  localparam int N      = 44100;
  localparam int MAXCYC = 95000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis_broadcaster_1to2_if #(.DATA_WIDTH(DW)) s_if ();
  axis_broadcaster_1to2_if #(.DATA_WIDTH(DW)) m1_if ();
  axis_broadcaster_1to2_if #(.DATA_WIDTH(DW)) m2_if ();

  axis_broadcaster_1to2 #(.DATA_WIDTH(DW)) dut (
    .AXIS_ACLK  (clk),
    .AXIS_ARESET(rst),
    .s_axis     (s_if),
    .m_axis1    (m1_if),
    .m_axis2    (m2_if)
  );

  int total = 0;
  int bad   = 0;

  logic [32:0] beats [N];
  int          src;
  int          r1;
  int          r2;
  int          cyc;
  bit          hs_s;
  bit          hs1;
  bit          hs2;
  bit          pv1;
  bit          pv2;
  bit          pr1;
  bit          pr2;
  logic [32:0] pb1;
  logic [32:0] pb2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic l);
    s_if.tvalid = v;
    s_if.tdata  = d;
    s_if.tlast  = l;
  endtask

  // Advance to just after the next active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset ----------------
    drive(1'b1, 32'h5555_AAAA, 1'b1);
    m1_if.tready = 1'b1;
    m2_if.tready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_s_tready", 64'(s_if.tready), 64'(1'b0));
    chk("rst_v1",       64'(m1_if.tvalid), 64'(1'b0));
    chk("rst_v2",       64'(m2_if.tvalid), 64'(1'b0));
    chk("rst_data1",    64'(m1_if.tdata), 64'(32'h0));
    chk("rst_data2",    64'(m2_if.tdata), 64'(32'h0));
    chk("rst_last1",    64'(m1_if.tlast), 64'(1'b0));
    drive(1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    #1;
    chk("rel_s_tready", 64'(s_if.tready), 64'(1'b1));

    // ---------------- streaming ----------------
    tick();
    drive(1'b1, 32'h00AB_CDEF, 1'b0);
    @(negedge clk);
    chk("str_v1_pre", 64'(m1_if.tvalid), 64'(1'b0));
    tick();
    drive(1'b1, 32'hFF54_3211, 1'b1);
    @(negedge clk);
    chk("str_a_d1", 64'(m1_if.tdata), 64'(32'h00AB_CDEF));
    chk("str_a_d2", 64'(m2_if.tdata), 64'(32'h00AB_CDEF));
    chk("str_a_l1", 64'(m1_if.tlast), 64'(1'b0));
    chk("str_a_v",  64'({m1_if.tvalid, m2_if.tvalid}), 64'(2'b11));
    chk("str_a_sr", 64'(s_if.tready), 64'(1'b1));
    tick();
    drive(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("str_b_d1", 64'(m1_if.tdata), 64'(32'hFF54_3211));
    chk("str_b_d2", 64'(m2_if.tdata), 64'(32'hFF54_3211));
    chk("str_b_l",  64'({m1_if.tlast, m2_if.tlast}), 64'(2'b11));
    chk("str_b_v",  64'({m1_if.tvalid, m2_if.tvalid}), 64'(2'b11));
    tick();
    @(negedge clk);
    chk("str_idle_v", 64'({m1_if.tvalid, m2_if.tvalid}), 64'(2'b00));

    // ---------------- branch 2 stall ----------------
    m2_if.tready = 1'b0;
    drive(1'b1, 32'h1234_5678, 1'b0);
    tick();
    // Next beat waits upstream; it must not overwrite the stalled one.
    drive(1'b1, 32'h9999_0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stl_v1", 64'(m1_if.tvalid), 64'(i == 0));
      chk("stl_v2", 64'(m2_if.tvalid), 64'(1'b1));
      chk("stl_d2", 64'(m2_if.tdata), 64'(32'h1234_5678));
      chk("stl_sr", 64'(s_if.tready), 64'(1'b0));
      tick();
    end
    m2_if.tready = 1'b1;
    #1;
    chk("stl_rel_sr", 64'(s_if.tready), 64'(1'b1));
    chk("stl_rel_v2", 64'(m2_if.tvalid), 64'(1'b1));
    tick();
    drive(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("stl_next_d", 64'(m1_if.tdata), 64'(32'h9999_0000));
    chk("stl_next_l", 64'(m2_if.tlast), 64'(1'b1));
    chk("stl_next_v", 64'({m1_if.tvalid, m2_if.tvalid}), 64'(2'b11));
    tick();

    // ---------------- simultaneous release and load ----------------
    drive(1'b1, 32'hCAFE_F00D, 1'b0);
    tick();
    drive(1'b1, 32'h0000_0001, 1'b0);
    @(negedge clk);
    chk("sim_sr", 64'(s_if.tready), 64'(1'b1));
    chk("sim_d0", 64'(m2_if.tdata), 64'(32'hCAFE_F00D));
    tick();
    drive(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("sim_d1", 64'(m1_if.tdata), 64'(32'h0000_0001));
    chk("sim_d2", 64'(m2_if.tdata), 64'(32'h0000_0001));
    chk("sim_v",  64'({m1_if.tvalid, m2_if.tvalid}), 64'(2'b11));
    tick();

    // ---------------- mid-operation reset ----------------
    m1_if.tready = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("mr_v1_pre", 64'(m1_if.tvalid), 64'(1'b1));
    #1 rst = 1'b1;
    #1;
    chk("mr_v", 64'({m1_if.tvalid, m2_if.tvalid}), 64'(2'b00));
    chk("mr_sr", 64'(s_if.tready), 64'(1'b0));
    chk("mr_d", 64'(m1_if.tdata), 64'(32'h0));
    #1 rst = 1'b0;
    m1_if.tready = 1'b1;
    drive(1'b1, 32'h0BAD_F00D, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("mr_post_d1", 64'(m1_if.tdata), 64'(32'h0BAD_F00D));
    chk("mr_post_d2", 64'(m2_if.tdata), 64'(32'h0BAD_F00D));
    chk("mr_post_l",  64'(m1_if.tlast), 64'(1'b1));
    chk("mr_post_v",  64'({m1_if.tvalid, m2_if.tvalid}), 64'(2'b11));
    tick();

    // ---------------- randomised stereo stream ----------------
    for (int i = 0; i < N; i++) begin
      beats[i] = {i[0], $urandom()};
    end
    src = 0;
    r1  = 0;
    r2  = 0;
    cyc = 0;
    pv1 = 1'b0;
    pv2 = 1'b0;
    pr1 = 1'b1;
    pr2 = 1'b1;
    pb1 = '0;
    pb2 = '0;
    drive(1'b1, beats[0][31:0], beats[0][32]);
    m1_if.tready = ($urandom_range(15, 0) != 0);
    m2_if.tready = ($urandom_range(15, 0) != 0);
    while ((r1 < N || r2 < N) && cyc < MAXCYC) begin
      @(negedge clk);
      if (pv1 && !pr1) begin
        chk("stab1", 64'({m1_if.tvalid, m1_if.tlast, m1_if.tdata}), 64'({1'b1, pb1}));
      end
      if (pv2 && !pr2) begin
        chk("stab2", 64'({m2_if.tvalid, m2_if.tlast, m2_if.tdata}), 64'({1'b1, pb2}));
      end
      hs_s = s_if.tvalid && s_if.tready;
      hs1  = m1_if.tvalid && m1_if.tready;
      hs2  = m2_if.tvalid && m2_if.tready;
      if (hs1) begin
        if (r1 < N) chk("rx1", 64'({m1_if.tlast, m1_if.tdata}), 64'(beats[r1]));
        else        chk("rx1_count", 64'(r1 + 1), 64'(N));
        r1++;
      end
      if (hs2) begin
        if (r2 < N) chk("rx2", 64'({m2_if.tlast, m2_if.tdata}), 64'(beats[r2]));
        else        chk("rx2_count", 64'(r2 + 1), 64'(N));
        r2++;
      end
      pv1 = m1_if.tvalid;
      pr1 = m1_if.tready;
      pb1 = {m1_if.tlast, m1_if.tdata};
      pv2 = m2_if.tvalid;
      pr2 = m2_if.tready;
      pb2 = {m2_if.tlast, m2_if.tdata};
      if (hs_s) src++;
      tick();
      cyc++;
      if (src >= N) begin
        drive(1'b0, 32'h0, 1'b0);
      end else begin
        // A presented beat stays up until taken.
        if (!(s_if.tvalid && !hs_s)) s_if.tvalid = ($urandom_range(15, 0) != 0);
        s_if.tdata = beats[src][31:0];
        s_if.tlast = beats[src][32];
      end
      m1_if.tready = ($urandom_range(15, 0) != 0);
      m2_if.tready = ($urandom_range(15, 0) != 0);
    end
    chk("rand_src_total", 64'(src), 64'(N));
    chk("rand_rx1_total", 64'(r1), 64'(N));
    chk("rand_rx2_total", 64'(r2), 64'(N));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
